ifetch_byte_seq: RTL and testbench
==================================

# ifetch_byte_seq

Byte-serial instruction fetch sequencer for the rv32i core. It sits directly upstream of the core's 16×8 synchronous-read memory and drives that memory's address and write-enable. It issues four consecutive byte reads per instruction, absorbing the memory's one-cycle registered-address read latency, and packs the bytes little-endian into a 32-bit word. The word goes to the decode stage over a valid/ready handshake, and the sequencer supports a PC redirect from the execute stage.

## Interface
- ADDR_W, 4: memory byte-address width; byte addresses wrap mod 2^ADDR_W
- DATA_W, 8: memory data width; fixed at 8
- PC_W, 32: program-counter width
- RESET_PC, 0: PC value loaded on reset
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  fetch enable; sampled in IDLE and on handshake
- redirect_valid  in  1  load redirect_pc; abort any fetch in progress
- redirect_pc  in  PC_W  new fetch PC; no alignment check
- mem_addr  out  ADDR_W  byte address to memory
- mem_we  out  1  memory write enable; tied 0
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr
- instr_valid  out  1  instr_data/instr_pc hold a packed instruction
- instr_ready  in  1  downstream accepts
- instr_data  out  32  {b3,b2,b1,b0}; b0 read from pc
- instr_pc  out  PC_W  PC of instr_data

## Operation
- States:
  - IDLE: nothing issued.
  - FETCH: byte counter cnt runs 0..4.
  - VALID: instruction presented.
- IDLE → FETCH when en=1, with cnt=0.
- FETCH:
  - cnt 0..3: mem_addr = pc[ADDR_W-1:0] + cnt, mod 2^ADDR_W.
  - cnt 1..4: capture mem_rdata into byte[cnt-1].
  - cnt increments each cycle.
  - At cnt=4: load instr_data and instr_pc=pc, set instr_valid, go to VALID.
- VALID: instr_data, instr_pc and instr_valid stay stable until instr_valid && instr_ready.
  - On the handshake: pc ← pc+4 mod 2^PC_W, clear instr_valid.
  - Then go to FETCH (cnt=0) if en=1, else IDLE.
- In IDLE and VALID, mem_addr = pc[ADDR_W-1:0], a harmless read.
- mem_we is constant 0.
- Redirect (any state), effective next cycle:
  - pc ← redirect_pc, cnt ← 0, instr_valid ← 0.
  - State ← FETCH if en=1, else IDLE.
  - Partial bytes are discarded.
- Redirect and handshake in the same cycle:
  - The handshake completes; downstream owns that instruction.
  - pc takes redirect_pc, not pc+4.
- en deasserted mid-FETCH: the fetch completes to VALID; no further fetch starts after the handshake.
- Reset (asynchronous, any time):
  - state=IDLE, pc=RESET_PC, cnt=0.
  - instr_valid=0, instr_data=0, instr_pc=0.
  - mem_addr=RESET_PC[ADDR_W-1:0], mem_we=0.

## Timing
- With en=1 from reset release:
  - cycle 0: IDLE.
  - cycles 1–5: FETCH with cnt 0–4.
  - cycle 6: instr_valid=1.
- Latency from the first en=1 cycle in IDLE to instr_valid: 6 cycles.
- Back-to-back with instr_ready=1: one instruction per 6 cycles (handshake cycle + 5 FETCH cycles).
- Redirect in cycle t: mem_addr = redirect_pc[ADDR_W-1:0] in cycle t+1; instr_valid=1 in cycle t+6.
- No combinational path from instr_ready or redirect_valid to mem_addr; mem_addr decodes from registered state only.
- instr_valid never drops without a handshake, except on redirect or reset.

## Structure
- Shared package ifetch_pkg:
  - typedef fetch_state_e {IDLE, FETCH, VALID}
  - localparam BYTES_PER_INSTR = 4
  - localparam INSTR_W = 32
- Single module, no sub-modules. The byte shift/pack register is inline: about 150 lines.

## Test plan
- Memory preloaded with mem[i]=i, en=1, instr_ready=1:
  - first output instr_data=0x03020100, instr_pc=0, in cycle 6 after reset release.
  - second output 0x07060504, instr_pc=4, 6 cycles later.
- Backpressure: instr_ready=0 for 3 cycles while instr_valid=1 → instr_data/instr_pc unchanged and mem_addr static. The handshake on the 4th cycle advances pc to 4.
- Wrap: redirect_pc=0xE → mem_addr sequence 0xE, 0xF, 0x0, 0x1 → instr_data=0x01000F0E.
- Redirect mid-fetch: redirect_pc=8 asserted at cnt=2 of the pc=0 fetch → the pc=0 word never appears; next output is 0x0B0A0908 with instr_pc=8, 6 cycles after the redirect.
- Simultaneous instr_valid && instr_ready && redirect_valid (pc=4 word, redirect_pc=0xC) → the pc=4 word is consumed once; next output is 0x0F0E0D0C with instr_pc=0xC.
- rst_n pulsed low at cnt=3 → outputs reset immediately (instr_valid=0, mem_addr=0); after release, the fetch restarts from RESET_PC with 0x03020100.

Source files
------------

// File: rtl/ifetch_byte_seq_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg : shared types and constants for the byte-serial fetch sequencer
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

    localparam int BYTES_PER_INSTR = 4;
    localparam int INSTR_W         = 32;
    localparam int CNT_W           = 3;

endpackage

`default_nettype wire

// File: rtl/ifetch_byte_seq_if.sv
// ----------------------------------------------------------------------------
// ifetch_byte_seq_if : fetch-to-decode instruction handshake (valid/ready)
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ifetch_byte_seq_if
    import ifetch_pkg::*;
#(
    parameter int PC_W = 32
);

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [PC_W-1:0]    instr_pc;

    modport master (
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );

endinterface

`default_nettype wire

// File: rtl/ifetch_byte_seq.sv
// ----------------------------------------------------------------------------
// ifetch_byte_seq : four byte reads per instruction, packed little-endian
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ifetch_byte_seq
    import ifetch_pkg::*;
#(
    parameter int              ADDR_W   = 4,
    parameter int              DATA_W   = 8,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              en_i,
    input  wire logic              redirect_valid_i,
    input  wire logic [PC_W-1:0]   redirect_pc_i,
    output      logic [ADDR_W-1:0] mem_addr_o,
    output      logic              mem_we_o,
    input  wire logic [DATA_W-1:0] mem_rdata_i,
    ifetch_byte_seq_if.master      instr_if
);

    fetch_state_e               state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [PC_W-1:0]            pc_q;
    logic [INSTR_W-DATA_W-1:0]  shift_q;
    logic                       instr_valid_q;
    logic [INSTR_W-1:0]         instr_data_q;
    logic [PC_W-1:0]            instr_pc_q;
    logic [1:0]                 addr_ofs;
    logic                       handshake;

    // Address is decoded from registered state only, so ready/redirect never reach it.
    always_comb begin
        addr_ofs = 2'd0;
        if (state_q == FETCH) begin
            addr_ofs = cnt_q[1:0];
        end
    end

    assign mem_addr_o = pc_q[ADDR_W-1:0] + ADDR_W'(addr_ofs);
    assign mem_we_o   = 1'b0;
    assign handshake  = instr_valid_q && instr_if.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            pc_q          <= RESET_PC;
            shift_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else if (redirect_valid_i) begin
            // A coincident handshake still completes: clearing valid is all it needs.
            pc_q          <= redirect_pc_i;
            cnt_q         <= '0;
            instr_valid_q <= 1'b0;
            state_q       <= en_i ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_i) begin
                        state_q <= FETCH;
                        cnt_q   <= '0;
                    end
                end
                FETCH: begin
                    if (cnt_q == CNT_W'(BYTES_PER_INSTR)) begin
                        instr_data_q  <= {mem_rdata_i, shift_q};
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= VALID;
                    end else begin
                        // Read data lags the address by a cycle; bytes shift in from the top.
                        if (cnt_q != '0) begin
                            shift_q <= {mem_rdata_i, shift_q[INSTR_W-DATA_W-1:DATA_W]};
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                VALID: begin
                    if (handshake) begin
                        pc_q          <= pc_q + PC_W'(BYTES_PER_INSTR);
                        instr_valid_q <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= en_i ? FETCH : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_if.instr_valid = instr_valid_q;
    assign instr_if.instr_data  = instr_data_q;
    assign instr_if.instr_pc    = instr_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_byte_seq.sv
// ----------------------------------------------------------------------------
// tb_ifetch_byte_seq : directed + random scoreboard bench for ifetch_byte_seq
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_byte_seq;
    import ifetch_pkg::*;

    localparam int ADDR_W = 4;
    localparam int PC_W   = 32;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              ready;
    logic              rv;
    logic [PC_W-1:0]   rpc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_rdata;
    logic [7:0]        mem [16];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          hs_cnt = 0;
    logic [31:0] exp_pc = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: address registered, data one cycle later.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    ifetch_byte_seq_if #(.PC_W(PC_W)) ifc ();
    assign ifc.instr_ready = ready;

    ifetch_byte_seq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (8),
        .PC_W     (PC_W),
        .RESET_PC ('0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_i             (en),
        .redirect_valid_i (rv),
        .redirect_pc_i    (rpc),
        .mem_addr_o       (mem_addr),
        .mem_we_o         (mem_we),
        .mem_rdata_i      (mem_rdata),
        .instr_if         (ifc)
    );

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [3:0] a;
        a = pc[3:0];
        return {mem[a + 4'd3], mem[a + 4'd2], mem[a + 4'd1], mem[a]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // One cycle of stimulus, driven at the negedge. The model tracks the PC of the
    // next instruction owed to decode: +4 after each delivery, or the redirect target.
    task automatic step(input logic e, input logic r, input logic v, input logic [31:0] p);
        logic hs;
        @(negedge clk);
        en = e; ready = r; rv = v; rpc = p;
        hs = ifc.instr_valid && r;
        if (hs) sb.push_back('{exp_pc, word_at(exp_pc)});
        if (v)       exp_pc = p;
        else if (hs) exp_pc = exp_pc + 32'd4;
    endtask

    task automatic apply_reset();
        #3;
        rst_n = 1'b0; en = 1'b0; ready = 1'b0; rv = 1'b0;
        #1;
        chk("rst_valid", 32'(ifc.instr_valid), 32'h0);
        chk("rst_data",  ifc.instr_data, 32'h0);
        chk("rst_pc",    ifc.instr_pc, 32'h0);
        chk("rst_addr",  32'(mem_addr), 32'h0);
        chk("rst_we",    32'(mem_we), 32'h0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic release_rst(input logic e, input logic r);
        rst_n = 1'b1; en = e; ready = r; rv = 1'b0;
        exp_pc = 32'h0;
    endtask

    // Monitor: pops the scoreboard on every handshake and checks output stability.
    logic        m_pv = 1'b0;
    logic        m_phs = 1'b0;
    logic        m_prv = 1'b0;
    logic [31:0] m_pd, m_pp;
    exp_t        m_e;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                m_pv = 1'b0;
            end else begin
                if (m_pv && !m_phs && !m_prv) begin
                    chk("hold_valid", 32'(ifc.instr_valid), 32'h1);
                    chk("hold_data",  ifc.instr_data, m_pd);
                    chk("hold_pc",    ifc.instr_pc, m_pp);
                end
                m_phs = ifc.instr_valid && ready;
                m_prv = rv;
                if (m_phs) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_instr: got pc %h data %h, expected none",
                                 ifc.instr_pc, ifc.instr_data);
                    end else begin
                        m_e = sb.pop_front();
                        chk("sb_pc",   ifc.instr_pc, m_e.pc);
                        chk("sb_data", ifc.instr_data, m_e.data);
                        hs_cnt++;
                    end
                end
                m_pv = ifc.instr_valid;
                m_pd = ifc.instr_data;
                m_pp = ifc.instr_pc;
            end
        end
    end

    initial begin
        logic [31:0] wrap_addr [4];
        rst_n = 1'b0; en = 1'b0; ready = 1'b0; rv = 1'b0; rpc = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        wrap_addr[0] = 32'hE; wrap_addr[1] = 32'hF; wrap_addr[2] = 32'h0; wrap_addr[3] = 32'h1;

        // Latency, backpressure, simultaneous redirect+handshake, en drop mid-fetch.
        @(negedge clk);
        apply_reset();
        release_rst(1'b1, 1'b0);
        for (int c = 1; c <= 33; c++) begin
            step((c <= 22), (c >= 9), (c == 15), 32'hC);
            if (c <= 4) chk("fetch_addr", 32'(mem_addr), 32'(c - 1));
            if (c == 5) chk("no_early_valid", 32'(ifc.instr_valid), 32'h0);
            if (c >= 6 && c <= 8) begin
                chk("bp_valid", 32'(ifc.instr_valid), 32'h1);
                chk("bp_data",  ifc.instr_data, 32'h03020100);
                chk("bp_pc",    ifc.instr_pc, 32'h0);
                chk("bp_addr",  32'(mem_addr), 32'h0);
            end
            if (c == 10) chk("pc_adv_addr", 32'(mem_addr), 32'h4);
            if (c == 14) chk("b2b_not_early", 32'(ifc.instr_valid), 32'h0);
            if (c == 15 || c == 21 || c == 27) chk("b2b_valid", 32'(ifc.instr_valid), 32'h1);
            if (c == 15) chk("second_data", ifc.instr_data, 32'h07060504);
            if (c == 16) chk("redir_hs_addr", 32'(mem_addr), 32'hC);
            if (c == 21) chk("redir_hs_data", ifc.instr_data, 32'h0F0E0D0C);
            if (c == 22) chk("wrap_pc10_addr", 32'(mem_addr), 32'h0);
            if (c == 27) chk("en_drop_pc", ifc.instr_pc, 32'h10);
            if (c == 28 || c == 33) begin
                chk("idle_addr",  32'(mem_addr), 32'h4);
                chk("idle_valid", 32'(ifc.instr_valid), 32'h0);
            end
        end

        // Redirect mid-fetch, address wrap, then asynchronous reset at cnt=3.
        apply_reset();
        release_rst(1'b1, 1'b1);
        for (int c = 1; c <= 19; c++) begin
            step(1'b1, 1'b1, (c == 3 || c == 9), (c == 3) ? 32'h8 : 32'hE);
            if (c == 4) chk("redir_addr", 32'(mem_addr), 32'h8);
            if (c >= 4 && c <= 8) chk("aborted_valid", 32'(ifc.instr_valid), 32'h0);
            if (c == 9) begin
                chk("redir_valid", 32'(ifc.instr_valid), 32'h1);
                chk("redir_data",  ifc.instr_data, 32'h0B0A0908);
            end
            if (c >= 10 && c <= 13) chk("wrap_addr", 32'(mem_addr), wrap_addr[c - 10]);
            if (c == 15) chk("wrap_data", ifc.instr_data, 32'h01000F0E);
            if (c == 19) chk("pre_rst_addr", 32'(mem_addr), 32'h5);
        end
        apply_reset();
        release_rst(1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (c == 6) chk("post_rst_data", ifc.instr_data, 32'h03020100);
        end

        // Random traffic over random memory contents.
        apply_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        release_rst(1'b1, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), $urandom);
        end
        for (int c = 0; c < 12; c++) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("random_progress", 32'(hs_cnt > 100), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
